sic1_mem_mmio: RTL and testbench
================================

Name: sic1_mem_mmio

Overview:
Parametrised next-generation SIC-1 memory subsystem. It provides a byte-addressable, word-organised flop array with two synchronous read ports and one byte write port. Writes use per-byte-lane enables, so no read-modify-write ordering constraint exists. Memory-mapped I/O has full handshakes: a one-entry input holding register (valid/ready), an output byte FIFO (valid/ready) and a status byte. The block sits between the SIC-1 core and the top-level I/O pins.

Parameters:
ADDR_W, 8, byte-address width; address space 2^ADDR_W bytes.
WORD_BYTES, 4, bytes per word (power of two, 1..8); word address width AW = ADDR_W - log2(WORD_BYTES).
OUT_DEPTH, 4, output FIFO entries (power of two, >=2).
ADDR_IN, 2^ADDR_W-3, input data byte address.
ADDR_OUT, 2^ADDR_W-2, output byte address.
ADDR_STAT, 2^ADDR_W-1, status byte address.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  byte write strobe
wr_addr  in  ADDR_W  byte write address
wr_byte  in  8  byte write data
ra_addr  in  AW  port A word address
ra_data  out  8*WORD_BYTES  port A read data, 1-cycle latency
rb_addr  in  AW  port B word address
rb_data  out  8*WORD_BYTES  port B read data, 1-cycle latency
rb_byte_idx  in  log2(WORD_BYTES)  lane select for rb_byte
rb_byte  out  8  selected lane of rb_data (combinational from rb_data)
in_data  in  8  external input byte
in_valid  in  1  in_data valid
in_ready  out  1  holding register empty
in_pop  in  1  core consumed the input byte (pulse)
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  sink accepts out_data
out_full  out  1  FIFO full; core stalls an output write while high

Behaviour:
- Reset (async assert, sync release): in_full=0, in_hold=0, FIFO empty (rd/wr ptrs=0, count=0), out_overflow=0, ra_data=rb_data=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_full=0. Storage array is not reset.
- Storage write: wr_en and wr_addr < ADDR_IN: only lane wr_addr[log2(WORD_BYTES)-1:0] of word wr_addr[ADDR_W-1:log2(WORD_BYTES)] is updated at the edge.
- Writes to ADDR_IN: ignored. Writes to ADDR_OUT: FIFO push only. Writes to ADDR_STAT: clear out_overflow. None of these touch storage.
- Reads: ra_data/rb_data registered at the edge after the address is presented. Read-first: a same-cycle write to the same word returns the pre-write byte.
- Per-lane read mux, evaluated on byte address {word_addr, lane} and sampled into the output register at the edge:
  - ADDR_IN -> in_hold (0 when in_full=0).
  - ADDR_OUT -> last byte pushed (out_last, reset 0).
  - ADDR_STAT -> {5'b0, out_overflow, out_full, in_full}.
  - Every other address -> storage.
- Input handshake: in_ready = !in_full (registered, no combinational path from in_pop). When in_valid & in_ready: in_hold <= in_data, in_full <= 1. in_pop clears in_full; in_pop with in_full=0 is a no-op. in_pop while in_valid is high: entry clears this cycle, new byte is accepted next cycle.
- Output FIFO: push = wr_en & wr_addr==ADDR_OUT; pop = out_valid & out_ready.
  - Push is accepted when count<OUT_DEPTH, or when full and pop occurs in the same cycle (count unchanged).
  - Push when full without pop: byte dropped, out_overflow <= 1 (sticky until a write to ADDR_STAT or reset).
  - Push and pop on a non-empty FIFO: count unchanged, both pointers advance.
  - Pointers wrap modulo OUT_DEPTH; count is log2(OUT_DEPTH)+1 bits.
  - out_data = mem[rd_ptr]; out_full = (count==OUT_DEPTH); out_last updates on every accepted push.
- Reset mid-transfer: FIFO contents are discarded and in_hold is cleared immediately on rst_n falling.

Decomposition:
- Package sic1_mem_pkg: default ADDR_IN/ADDR_OUT/ADDR_STAT offsets, status bit indices (STAT_IN_FULL=0, STAT_OUT_FULL=1, STAT_OVF=2), lane-index function.
- Sub-module sic1_byte_fifo (parameter DEPTH): push/pop/full/empty/count logic with the simultaneous full push+pop rule.

Test Plan:
- Write 0xAA to addr 5, 0xBB to addr 6; read word 1 -> ra_data = 0x00BBAA00 on lanes (lanes 0/3 previously written 0), 1 cycle after address.
- Same-cycle write 0x11 to addr 4 and read of word 1 -> old value returned; next read shows lane0=0x11.
- in_valid with 0x5A -> in_ready drops the next cycle; read word 63 lane1 = 0x5A, lane3 = 0x01; in_pop -> in_ready=1, lane1 reads 0.
- Push 4 bytes to ADDR_OUT with out_ready=0 -> out_full=1. A 5th push is dropped and status reads 0x06. Write ADDR_STAT -> status 0x02. Drain yields the 4 bytes in order.
- FIFO full with out_ready=1 and push 0x77 in the same cycle -> accepted, count stays 4, no overflow.
- Assert rst_n=0 mid-drain without a clock edge -> out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/sic1_mem_pkg.sv
// Shared constants and helpers for the SIC-1 memory subsystem: MMIO offsets
// from the top of the address space, status bit positions and lane indexing.
package sic1_mem_pkg;

    localparam int OFS_IN   = 3;
    localparam int OFS_OUT  = 2;
    localparam int OFS_STAT = 1;

    localparam int STAT_IN_FULL  = 0;
    localparam int STAT_OUT_FULL = 1;
    localparam int STAT_OVF      = 2;

    function automatic int addr_in_of(input int addr_w);
        return (1 << addr_w) - OFS_IN;
    endfunction

    function automatic int addr_out_of(input int addr_w);
        return (1 << addr_w) - OFS_OUT;
    endfunction

    function automatic int addr_stat_of(input int addr_w);
        return (1 << addr_w) - OFS_STAT;
    endfunction

    function automatic int lane_of(input int byte_addr, input int word_bytes);
        return byte_addr % word_bytes;
    endfunction

endpackage

// File: rtl/sic1_byte_fifo.sv
// Byte FIFO with power-of-two depth; a push into a full FIFO is accepted
// only when a pop happens in the same cycle, otherwise it is reported as dropped.
module sic1_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       push_ok,
    output logic       drop
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   count_r;
    logic          pop_ok_s;

    assign empty    = (count_r == '0);
    assign full     = (count_r == (PW+1)'(DEPTH));
    assign pop_ok_s = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok_s);
    assign drop     = push & full & ~pop_ok_s;
    assign head     = empty ? 8'h00 : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok)  wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/sic1_mem_mmio.sv
// SIC-1 memory: word-organised byte-writable flop array with two registered
// read ports, plus MMIO input register, output FIFO and status byte at the top.
module sic1_mem_mmio
    import sic1_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int ADDR_IN    = addr_in_of(ADDR_W),
    parameter int ADDR_OUT   = addr_out_of(ADDR_W),
    parameter int ADDR_STAT  = addr_stat_of(ADDR_W),
    localparam int LW = $clog2(WORD_BYTES),
    localparam int IW = (LW > 0) ? LW : 1,
    localparam int AW = ADDR_W - LW,
    localparam int DW = 8 * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_byte,
    input  logic [AW-1:0]     ra_addr,
    output logic [DW-1:0]     ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DW-1:0]     rb_data,
    input  logic [IW-1:0]     rb_byte_idx,
    output logic [7:0]        rb_byte,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_pop,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_full
);
    localparam logic [ADDR_W-1:0] A_IN   = ADDR_IN[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] A_OUT  = ADDR_OUT[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_STAT[ADDR_W-1:0];

    logic [DW-1:0] mem_r [2**AW];
    logic          in_full_r;
    logic [7:0]    in_hold_r;
    logic [7:0]    out_last_r;
    logic          ovf_r;
    logic [7:0]    stat_s;
    logic [7:0]    in_byte_s;
    logic [DW-1:0] ra_next_s;
    logic [DW-1:0] rb_next_s;
    logic          push_s;
    logic          push_ok_s;
    logic          drop_s;
    logic          empty_s;
    logic [AW-1:0] wr_word_s;
    int            wr_lane_s;

    function automatic logic [7:0] pick_byte(
        input logic [ADDR_W-1:0] ba,
        input logic [7:0]        in_b,
        input logic [7:0]        last_b,
        input logic [7:0]        stat_b,
        input logic [7:0]        mem_b
    );
        logic [7:0] r;
        if (ba == A_IN)        r = in_b;
        else if (ba == A_OUT)  r = last_b;
        else if (ba == A_STAT) r = stat_b;
        else                   r = mem_b;
        return r;
    endfunction

    assign push_s    = wr_en & (wr_addr == A_OUT);
    assign wr_word_s = AW'(wr_addr >> LW);
    assign wr_lane_s = lane_of(int'(wr_addr), WORD_BYTES);
    assign in_ready  = ~in_full_r;
    assign out_valid = ~empty_s;
    assign in_byte_s = in_full_r ? in_hold_r : 8'h00;

    sic1_byte_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (wr_byte),
        .pop       (out_ready),
        .head      (out_data),
        .full      (out_full),
        .empty     (empty_s),
        .push_ok   (push_ok_s),
        .drop      (drop_s)
    );

    // Per-lane read mux: MMIO bytes overlay storage at their byte addresses.
    always_comb begin
        stat_s = 8'h00;
        stat_s[STAT_IN_FULL]  = in_full_r;
        stat_s[STAT_OUT_FULL] = out_full;
        stat_s[STAT_OVF]      = ovf_r;
        ra_next_s = '0;
        rb_next_s = '0;
        for (int l = 0; l < WORD_BYTES; l++) begin
            ra_next_s[l*8 +: 8] = pick_byte((ADDR_W'(ra_addr) << LW) | ADDR_W'(l),
                                            in_byte_s, out_last_r, stat_s, mem_r[ra_addr][l*8 +: 8]);
            rb_next_s[l*8 +: 8] = pick_byte((ADDR_W'(rb_addr) << LW) | ADDR_W'(l),
                                            in_byte_s, out_last_r, stat_s, mem_r[rb_addr][l*8 +: 8]);
        end
    end

    generate
        if (LW > 0) begin : g_lane_sel
            assign rb_byte = rb_data[{rb_byte_idx, 3'b000} +: 8];
        end else begin : g_single_lane
            logic unused_idx;
            assign unused_idx = rb_byte_idx[0];
            assign rb_byte    = rb_data[7:0];
        end
    endgenerate

    // Storage lane write; the MMIO addresses never reach the array.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < A_IN)) mem_r[wr_word_s][wr_lane_s*8 +: 8] <= wr_byte;
    end

    // Registered read ports, input holding register and MMIO side state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_data    <= '0;
            rb_data    <= '0;
            in_full_r  <= 1'b0;
            in_hold_r  <= 8'h00;
            out_last_r <= 8'h00;
            ovf_r      <= 1'b0;
        end else begin
            ra_data <= ra_next_s;
            rb_data <= rb_next_s;
            if (in_valid && !in_full_r) begin
                in_hold_r <= in_data;
                in_full_r <= 1'b1;
            end else if (in_pop) begin
                in_full_r <= 1'b0;
            end
            if (push_ok_s) out_last_r <= wr_byte;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (wr_en && (wr_addr == A_STAT)) begin
                ovf_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sic1_mem_mmio.sv
// Directed bench for sic1_mem_mmio: storage lanes, read-first, input handshake,
// output FIFO overflow/status and asynchronous reset.
module tb_sic1_mem_mmio;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_byte;
    logic [5:0]  ra_addr;
    logic [31:0] ra_data;
    logic [5:0]  rb_addr;
    logic [31:0] rb_data;
    logic [1:0]  rb_byte_idx;
    logic [7:0]  rb_byte;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_pop;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_full;

    int checks = 0;
    int errors = 0;

    sic1_mem_mmio dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_byte     (wr_byte),
        .ra_addr     (ra_addr),
        .ra_data     (ra_data),
        .rb_addr     (rb_addr),
        .rb_data     (rb_data),
        .rb_byte_idx (rb_byte_idx),
        .rb_byte     (rb_byte),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pop      (in_pop),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_full    (out_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_byte = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'h00; wr_byte = 8'h00;
        ra_addr = 6'd0; rb_addr = 6'd0; rb_byte_idx = 2'd0;
        in_data = 8'h00; in_valid = 1'b0; in_pop = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_full",  32'(out_full),  32'd0);
        chk("rst_ra_data",   ra_data,        32'd0);
        chk("rst_rb_data",   rb_data,        32'd0);
        #10 rst_n = 1'b1;

        // storage lanes
        wr(8'd4, 8'h00); wr(8'd5, 8'hAA); wr(8'd6, 8'hBB); wr(8'd7, 8'h00);
        wr(8'd252, 8'hC3);
        ra_addr = 6'd1; rb_addr = 6'd1; rb_byte_idx = 2'd2;
        tick();
        chk("word1_read",  ra_data,         32'h00BBAA00);
        chk("word1_portb", rb_data,         32'h00BBAA00);
        chk("rb_byte_l2",  32'(rb_byte),    32'h000000BB);

        // read-first on same-cycle write
        wr(8'd4, 8'h11);
        chk("read_first_old", ra_data, 32'h00BBAA00);
        tick();
        chk("read_after_wr",  ra_data, 32'h00BBAA11);

        // writes to the input address are ignored
        wr(8'd253, 8'hEE);
        ra_addr = 6'd63;
        tick();
        chk("mmio_idle_word", ra_data, 32'h000000C3);

        // input handshake
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("in_ready_drop", 32'(in_ready), 32'd0);
        tick();
        chk("in_word63", ra_data, 32'h01005AC3);
        in_pop = 1'b1;
        tick();
        in_pop = 1'b0;
        chk("in_ready_pop", 32'(in_ready), 32'd1);
        tick();
        chk("in_word63_clr", ra_data, 32'h000000C3);

        // output FIFO fill and overflow
        rb_addr = 6'd63;
        wr(8'd254, 8'h10); wr(8'd254, 8'h20); wr(8'd254, 8'h30); wr(8'd254, 8'h40);
        chk("fifo_full",   32'(out_full),  32'd1);
        chk("fifo_valid",  32'(out_valid), 32'd1);
        chk("fifo_head",   32'(out_data),  32'h10);
        wr(8'd254, 8'h50);
        tick();
        chk("stat_ovf",    rb_data[31:16], 32'h0640);
        wr(8'd255, 8'h00);
        tick();
        chk("stat_clr",    rb_data[31:24], 32'h02);

        // drain in order
        out_ready = 1'b1;
        tick(); chk("drain_20", 32'(out_data), 32'h20);
        tick(); chk("drain_30", 32'(out_data), 32'h30);
        tick(); chk("drain_40", 32'(out_data), 32'h40);
        tick(); chk("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // full FIFO with simultaneous push and pop
        wr(8'd254, 8'h61); wr(8'd254, 8'h62); wr(8'd254, 8'h63); wr(8'd254, 8'h64);
        out_ready = 1'b1;
        wr(8'd254, 8'h77);
        out_ready = 1'b0;
        chk("pp_full",  32'(out_full), 32'd1);
        chk("pp_head",  32'(out_data), 32'h62);
        tick();
        chk("pp_stat",  rb_data[31:16], 32'h0277);

        // asynchronous reset mid-drain
        out_ready = 1'b1; in_data = 8'h33; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_head",  32'(out_data), 32'h63);
        chk("pre_rst_in",    32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_full",  32'(out_full),  32'd0);
        chk("arst_rb_data",   rb_data,        32'd0);
        #10 rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
